// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: funct3 encodings, FSM states
// and the lane helpers used for byte enables, store replication and load extension.
package mem_stage_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic {IDLE, BUSY} state_t;

   // Size is carried in funct3[1:0]; size code 3 has no legal access width.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'd0:    return 1'b0;
         2'd1:    return a[0];
         2'd2:    return a != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'd0:    return 4'b0001 << a;
         2'd1:    return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] rs2);
      case (f3[1:0])
         2'd0:    return {4{rs2[7:0]}};
         2'd1:    return {2{rs2[15:0]}};
         default: return rs2;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] word);
      logic [31:0] shifted;
      logic [15:0] half;
      shifted = word >> {a, 3'b000};
      half    = a[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    return {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   return {24'd0, shifted[7:0]};
         F3_H:    return {{16{half[15]}}, half};
         F3_HU:   return {16'd0, half};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM inputs, stall back-pressure and MEM/WB outputs of the MEM stage.
interface mem_access_stage_if;

   logic        exmem_valid;
   logic [31:0] exmem_alu_res;
   logic [31:0] exmem_rs2;
   logic        exmem_wb;
   logic        exmem_mem_read;
   logic        exmem_mem_write;
   logic [2:0]  exmem_funct3;
   logic [4:0]  exmem_rd;

   logic        mem_stall;
   logic        memwb_valid;
   logic        memwb_wb;
   logic        memwb_mem_read;
   logic [31:0] memwb_alu_res;
   logic [31:0] memwb_load_data;
   logic [4:0]  memwb_rd;
   logic        memwb_misalign;

   modport master (
      output exmem_valid, exmem_alu_res, exmem_rs2, exmem_wb, exmem_mem_read,
             exmem_mem_write, exmem_funct3, exmem_rd,
      input  mem_stall, memwb_valid, memwb_wb, memwb_mem_read, memwb_alu_res,
             memwb_load_data, memwb_rd, memwb_misalign
   );

   modport slave (
      input  exmem_valid, exmem_alu_res, exmem_rs2, exmem_wb, exmem_mem_read,
             exmem_mem_write, exmem_funct3, exmem_rd,
      output mem_stall, memwb_valid, memwb_wb, memwb_mem_read, memwb_alu_res,
             memwb_load_data, memwb_rd, memwb_misalign
   );

endinterface

// File: rtl/mem_access_stage_data_mem.sv
// Word-organised data memory: byte-enable synchronous write, combinational read.
module data_mem #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // NOTE: the array has no reset; clearing it would turn RAM into flops and contents must survive rst.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: classifies the EX/MEM slot, runs loads/stores with a fixed latency
// (stalling upstream meanwhile) and registers the outcome into MEM/WB.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int MEM_LAT = 2
) (
   input logic               clk,
   input logic               rst,
   mem_access_stage_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(MEM_LAT + 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          mem_op, fault, go, complete, we;
   logic [1:0]    lane;
   logic [31:0]   rdata;

   assign lane   = bus.exmem_alu_res[1:0];
   assign mem_op = bus.exmem_valid && (bus.exmem_mem_read || bus.exmem_mem_write);
   assign fault  = mem_op && misaligned(bus.exmem_funct3, lane);
   assign go     = mem_op && !fault;
   // A load with mem_write also set is still a load; reset kills an in-flight write.
   assign we     = complete && go && bus.exmem_mem_write && !bus.exmem_mem_read && !rst;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      complete      = 1'b0;
      bus.mem_stall = 1'b0;
      case (state)
         IDLE: begin
            if (bus.exmem_valid) begin
               if (go && MEM_LAT > 1) begin
                  bus.mem_stall = 1'b1;
                  state_n       = BUSY;
                  cnt_n         = CW'(MEM_LAT - 1);
               end else begin
                  complete = 1'b1;
               end
            end
         end
         BUSY: begin
            if (cnt == CW'(1)) begin
               complete = 1'b1;
               state_n  = IDLE;
            end else begin
               bus.mem_stall = 1'b1;
               cnt_n         = cnt - CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   data_mem #(.DEPTH(DEPTH), .AW(AW)) u_data_mem (
      .clk   (clk),
      .we    (we),
      .be    (byte_en(bus.exmem_funct3, lane)),
      .idx   (bus.exmem_alu_res[AW+1:2]),
      .wdata (store_data(bus.exmem_funct3, bus.exmem_rs2)),
      .rdata (rdata)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         cnt                 <= '0;
         bus.memwb_valid     <= 1'b0;
         bus.memwb_wb        <= 1'b0;
         bus.memwb_mem_read  <= 1'b0;
         bus.memwb_alu_res   <= '0;
         bus.memwb_load_data <= '0;
         bus.memwb_rd        <= '0;
         bus.memwb_misalign  <= 1'b0;
      end else begin
         state               <= state_n;
         cnt                 <= cnt_n;
         bus.memwb_valid     <= complete;
         bus.memwb_wb        <= complete && bus.exmem_wb && !fault;
         bus.memwb_mem_read  <= complete && bus.exmem_mem_read;
         bus.memwb_alu_res   <= complete ? bus.exmem_alu_res : '0;
         bus.memwb_load_data <= (complete && go && bus.exmem_mem_read)
                                ? load_ext(bus.exmem_funct3, lane, rdata) : '0;
         bus.memwb_rd        <= complete ? bus.exmem_rd : '0;
         bus.memwb_misalign  <= complete && fault;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage at MEM_LAT = 1, 2 and 3 sharing one
// EX/MEM driver; a selector picks which instance is being observed.
module tb_mem_access_stage;
   import mem_stage_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        valid = 1'b0, wb = 1'b0, mr = 1'b0, mw = 1'b0;
   logic [31:0] alu = '0, rs2 = '0;
   logic [2:0]  f3 = '0;
   logic [4:0]  rd = '0;
   int          sel = 2;

   mem_access_stage_if if1 ();
   mem_access_stage_if if2 ();
   mem_access_stage_if if3 ();

   assign {if1.exmem_valid, if1.exmem_alu_res, if1.exmem_rs2, if1.exmem_wb, if1.exmem_mem_read,
           if1.exmem_mem_write, if1.exmem_funct3, if1.exmem_rd} = {valid, alu, rs2, wb, mr, mw, f3, rd};
   assign {if2.exmem_valid, if2.exmem_alu_res, if2.exmem_rs2, if2.exmem_wb, if2.exmem_mem_read,
           if2.exmem_mem_write, if2.exmem_funct3, if2.exmem_rd} = {valid, alu, rs2, wb, mr, mw, f3, rd};
   assign {if3.exmem_valid, if3.exmem_alu_res, if3.exmem_rs2, if3.exmem_wb, if3.exmem_mem_read,
           if3.exmem_mem_write, if3.exmem_funct3, if3.exmem_rd} = {valid, alu, rs2, wb, mr, mw, f3, rd};

   mem_access_stage #(.DEPTH(1024), .MEM_LAT(1)) u_lat1 (.clk(clk), .rst(rst), .bus(if1.slave));
   mem_access_stage #(.DEPTH(1024), .MEM_LAT(2)) u_lat2 (.clk(clk), .rst(rst), .bus(if2.slave));
   mem_access_stage #(.DEPTH(1024), .MEM_LAT(3)) u_lat3 (.clk(clk), .rst(rst), .bus(if3.slave));

   logic        o_stall, o_valid, o_wb, o_mr, o_mis;
   logic [31:0] o_alu, o_ld;
   logic [4:0]  o_rd;

   always_comb begin
      {o_stall, o_valid, o_wb, o_mr, o_mis, o_alu, o_ld, o_rd} =
         {if2.mem_stall, if2.memwb_valid, if2.memwb_wb, if2.memwb_mem_read, if2.memwb_misalign,
          if2.memwb_alu_res, if2.memwb_load_data, if2.memwb_rd};
      if (sel == 1)
         {o_stall, o_valid, o_wb, o_mr, o_mis, o_alu, o_ld, o_rd} =
            {if1.mem_stall, if1.memwb_valid, if1.memwb_wb, if1.memwb_mem_read, if1.memwb_misalign,
             if1.memwb_alu_res, if1.memwb_load_data, if1.memwb_rd};
      else if (sel == 3)
         {o_stall, o_valid, o_wb, o_mr, o_mis, o_alu, o_ld, o_rd} =
            {if3.mem_stall, if3.memwb_valid, if3.memwb_wb, if3.memwb_mem_read, if3.memwb_misalign,
             if3.memwb_alu_res, if3.memwb_load_data, if3.memwb_rd};
   end

   int n_checks = 0;
   int n_fail   = 0;
   int stalls;
   logic bubble_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Called just after a rising edge; returns just after the completion edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [4:0] r, input logic rd_op, input logic wr_op,
                        input logic [2:0] f);
      valid = 1'b1; alu = a; rs2 = d; wb = w; rd = r; mr = rd_op; mw = wr_op; f3 = f;
      stalls       = 0;
      bubble_valid = 1'b0;
      #1;
      while (o_stall && stalls < 20) begin
         @(posedge clk);
         #1;
         stalls++;
         if (o_valid) bubble_valid = 1'b1;
      end
      if (stalls >= 20) check("stall_timeout", 32'(stalls), 32'd0);
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   initial begin
      // ---------------- MEM_LAT = 2 ----------------
      sel = 2;
      do_reset();
      #1;
      check("rst_stall", 32'(o_stall), 32'd0);
      check("rst_ctrl", {o_valid, o_wb, o_mr, o_mis, o_rd}, 32'd0);
      check("rst_alu", o_alu, 32'd0);
      check("rst_ld", o_ld, 32'd0);

      issue(32'h10, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 1'b1, F3_W);
      check("sw_stalls", 32'(stalls), 32'd1);
      check("sw_bubble", 32'(bubble_valid), 32'd0);
      check("sw_valid", 32'(o_valid), 32'd1);
      check("sw_ld", o_ld, 32'd0);

      issue(32'h10, 32'h0, 1'b1, 5'd3, 1'b1, 1'b0, F3_W);
      check("lw_stalls", 32'(stalls), 32'd1);
      check("lw_data", o_ld, 32'hDEADBEEF);
      check("lw_ctrl", {o_valid, o_wb, o_mr, o_mis, o_rd}, {23'd0, 4'b1110, 5'd3});

      issue(32'h20, 32'h11223344, 1'b0, 5'd0, 1'b0, 1'b1, F3_W);
      issue(32'h21, 32'h12345680, 1'b0, 5'd0, 1'b0, 1'b1, F3_B);
      issue(32'h21, 32'h0, 1'b1, 5'd4, 1'b1, 1'b0, F3_B);
      check("lb", o_ld, 32'hFFFFFF80);
      issue(32'h21, 32'h0, 1'b1, 5'd4, 1'b1, 1'b0, F3_BU);
      check("lbu", o_ld, 32'h00000080);
      issue(32'h20, 32'h0, 1'b1, 5'd4, 1'b1, 1'b0, F3_W);
      check("sb_lanes", o_ld, 32'h11228044);

      issue(32'h0, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 1'b1, F3_W);
      issue(32'h2, 32'hAAAA8001, 1'b0, 5'd0, 1'b0, 1'b1, F3_H);
      issue(32'h2, 32'h0, 1'b1, 5'd6, 1'b1, 1'b0, F3_H);
      check("lh", o_ld, 32'hFFFF8001);
      issue(32'h2, 32'h0, 1'b1, 5'd6, 1'b1, 1'b0, F3_HU);
      check("lhu", o_ld, 32'h00008001);
      issue(32'h0, 32'h0, 1'b1, 5'd6, 1'b1, 1'b0, F3_W);
      check("sh_lanes", o_ld, 32'h8001F00D);

      issue(32'h4, 32'h55667788, 1'b0, 5'd0, 1'b0, 1'b1, F3_W);
      issue(32'h6, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0, F3_W);
      check("mis_stalls", 32'(stalls), 32'd0);
      check("mis_ctrl", {o_valid, o_wb, o_mr, o_mis, o_rd}, {23'd0, 4'b1011, 5'd7});
      check("mis_ld", o_ld, 32'd0);
      issue(32'h6, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 1'b1, F3_W);
      check("mis_sw_flag", 32'(o_mis), 32'd1);
      issue(32'h8, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0, 3'd3);
      check("f3_3_flag", 32'(o_mis), 32'd1);
      issue(32'h4, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0, F3_W);
      check("mis_no_write", o_ld, 32'h55667788);

      issue(32'h1234, 32'h0, 1'b1, 5'd5, 1'b0, 1'b0, F3_W);
      check("alu_stalls", 32'(stalls), 32'd0);
      check("alu_ctrl", {o_valid, o_wb, o_mr, o_mis, o_rd}, {23'd0, 4'b1100, 5'd5});
      check("alu_res", o_alu, 32'h1234);
      check("alu_ld", o_ld, 32'd0);
      @(posedge clk);
      #1;
      check("bubble_valid", 32'(o_valid), 32'd0);

      // ---------------- MEM_LAT = 3, reset mid-flight ----------------
      sel = 3;
      do_reset();
      issue(32'h40, 32'h0BADF00D, 1'b0, 5'd0, 1'b0, 1'b1, F3_W);
      check("l3_sw_stalls", 32'(stalls), 32'd2);
      valid = 1'b1; alu = 32'h40; rs2 = 32'h12345678; wb = 1'b0; rd = 5'd0;
      mr = 1'b0; mw = 1'b1; f3 = F3_W;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      rst   = 1'b0;
      #1;
      check("l3_rst_stall", 32'(o_stall), 32'd0);
      check("l3_rst_ctrl", {o_valid, o_wb, o_mr, o_mis, o_rd}, 32'd0);
      check("l3_rst_alu", o_alu, 32'd0);
      @(posedge clk);
      #1;
      issue(32'h40, 32'h0, 1'b1, 5'd9, 1'b1, 1'b0, F3_W);
      check("l3_lw_stalls", 32'(stalls), 32'd2);
      check("l3_abort", o_ld, 32'h0BADF00D);

      // ---------------- MEM_LAT = 1 ----------------
      sel = 1;
      do_reset();
      issue(32'h44, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 1'b1, F3_W);
      check("l1_sw_stalls", 32'(stalls), 32'd0);
      issue(32'h44, 32'h0, 1'b1, 5'd2, 1'b1, 1'b0, F3_W);
      check("l1_lw_stalls", 32'(stalls), 32'd0);
      check("l1_lw", o_ld, 32'hA5A5A5A5);
      issue(32'h47, 32'h0, 1'b1, 5'd2, 1'b1, 1'b1, F3_BU);
      check("l1_rw_load", o_ld, 32'h000000A5);
      issue(32'h44, 32'h0, 1'b1, 5'd2, 1'b1, 1'b0, F3_W);
      check("l1_rw_nowrite", o_ld, 32'hA5A5A5A5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM stage of the five-stage pipeline. It sits directly downstream of the EX/MEM register and consumes its ALU result, store data, control bits and rd. It performs byte, half and word loads and stores against an internal data memory whose access latency is configurable, and it stalls upstream while an access is in flight. Results are registered into MEM/WB outputs for the write-back stage.

Parameters:
DEPTH, 1024, data memory size in 32-bit words; power of 2; index = addr[log2(DEPTH)+1:2], upper address bits ignored (wrap).
MEM_LAT, 2, cycles from a memory op being presented to its result appearing on the MEM/WB outputs; must be >= 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
exmem_valid  in  1  EX/MEM slot holds a real instruction
exmem_alu_res  in  32  ALU result; used as byte address for memory ops
exmem_rs2  in  32  store data
exmem_wb  in  1  register write-back enable
exmem_mem_read  in  1  load
exmem_mem_write  in  1  store
exmem_funct3  in  3  size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
exmem_rd  in  5  destination register
mem_stall  out  1  hold EX/MEM and all upstream stages this cycle
memwb_valid  out  1  MEM/WB slot valid
memwb_wb  out  1  write-back enable
memwb_mem_read  out  1  selects load data in WB mux
memwb_alu_res  out  32  passed ALU result
memwb_load_data  out  32  extended load result; 0 for non-loads
memwb_rd  out  5  destination register
memwb_misalign  out  1  access fault flag

Behaviour:
- Reset: FSM = IDLE, counter = 0, mem_stall = 0, all memwb_* = 0. Memory contents are not cleared. Reset during BUSY aborts the op and no write occurs.
- Classification, in IDLE with exmem_valid=1:
  - A memory op is mem_read | mem_write. If both are set, the op is a load and the write is suppressed.
  - Fault: H/HU with addr[0]!=0, W with addr[1:0]!=0, or funct3[1:0]==3.
- Non-memory op or fault: captured into MEM/WB at the next edge, no stall, no memory write.
  - On fault, memwb_misalign = 1 and memwb_wb is forced to 0.
- Valid memory op with MEM_LAT=1: access happens and is captured at the next edge; no stall.
- Valid memory op with MEM_LAT>1:
  - mem_stall = 1 combinationally in the presenting cycle.
  - FSM goes to BUSY with cnt = MEM_LAT-1.
- BUSY:
  - mem_stall = 1 while cnt != 1, and cnt decrements each cycle.
  - When cnt == 1: mem_stall = 0, the access is performed, the result is captured into MEM/WB at that edge, and the FSM returns to IDLE.
  - Upstream holds inputs stable while stalled; the stage latches nothing new during BUSY.
- Bubbles: memwb_valid = 0 at every edge where no instruction completes (stall cycles, or exmem_valid = 0).
- Stores are written at the completion edge:
  - SB: byte lane addr[1:0] gets rs2[7:0].
  - SH: half lane addr[1] gets rs2[15:0].
  - SW: full word.
  - Other lanes are unchanged.
- Loads read the memory combinationally at completion, select the lane, then extend:
  - B and H are sign-extended.
  - BU and HU are zero-extended.
  - W is unchanged.
- A load issued directly after a store to the same word returns the stored data, since the write has completed one or more edges earlier.
- memwb_alu_res, memwb_rd and memwb_mem_read pass through unchanged for every completed instruction.

Decomposition:
- Package mem_stage_pkg holds:
  - funct3 constants: F3_B = 0, F3_H = 1, F3_W = 2, F3_BU = 4, F3_HU = 5.
  - FSM enum: IDLE, BUSY.
  - Helper functions for lane select/extend and byte-enable generation.
- Sub-module data_mem: DEPTH x 32 array with 4-bit byte-enable synchronous write on clk and combinational read. No reset.

Test Plan:
- MEM_LAT=2, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_stall is high one cycle per op; memwb_load_data = 0xDEADBEEF two cycles after the LW is presented; memwb_valid = 0 in the stall bubble.
- SB 0x80 to addr 0x21, then LB 0x21 and LBU 0x21 -> 0xFFFFFF80 and 0x00000080; bytes 0x20, 0x22 and 0x23 are unchanged.
- SH 0x8001 to addr 0x2, then LH and LHU at 0x2 -> 0xFFFF8001 and 0x00008001; LW 0x0 upper half = 0x8001.
- LW addr 0x6 with wb=1 -> no stall, memwb_misalign = 1, memwb_wb = 0; memory is unmodified on a following read.
- ADD-type op (wb=1, rd=5, alu_res 0x1234), then bubble -> next edge gives memwb_valid = 1, rd = 5, alu_res = 0x1234, load_data = 0; the following edge gives memwb_valid = 0.
- MEM_LAT=3, SW in flight, rst asserted in the 2nd BUSY cycle -> outputs 0 and FSM IDLE next edge; a subsequent LW of that address returns its old value. Also run MEM_LAT=1 -> mem_stall never asserts.
